// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if
// Bundles the request/response handshake and the data-BRAM port of the
// load/store unit into one interface.
//   master modport : the LSU itself (takes requests, drives the BRAM port)
//   slave modport  : the surrounding core and BRAM
// Signals:
//   req_valid/req_ready         request handshake
//   req_we, req_funct3          store flag and RV32I access width/sign
//   req_addr, req_wdata         byte address and store data (rs2)
//   rsp_valid, rsp_rdata        one-cycle response pulse and load data
//   rsp_err                     access rejected
//   mem_w_addr/mem_w_dat/mem_w_enb/mem_byte_enb   BRAM write port
//   mem_r_addr/mem_r_enb/mem_r_dat                BRAM read port
interface lsu_mem_master_if #(
  parameter int ADDR_W = 12
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [31:0]       mem_w_dat;
  logic              mem_w_enb;
  logic [3:0]        mem_byte_enb;
  logic [ADDR_W-1:0] mem_r_addr;
  logic              mem_r_enb;
  logic [31:0]       mem_r_dat;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_dat,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_w_addr, mem_w_dat, mem_w_enb, mem_byte_enb,
           mem_r_addr, mem_r_enb
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_dat,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_w_addr, mem_w_dat, mem_w_enb, mem_byte_enb,
           mem_r_addr, mem_r_enb
  );

endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store initiator between the rv32i execute stage and the 32-bit data
// BRAM. One request is taken per transaction; stores get byte lanes and
// replicated write data, loads wait RD_LATENCY cycles on the read port and
// return sign/zero-extended data on a one-cycle response pulse.
// Ports:
//   clk   core clock
//   rst   synchronous active-low reset
//   bus   lsu_mem_master_if.master (request, response and BRAM signals)
//   busy  high whenever the unit is not idle
// Parameters:
//   ADDR_W      BRAM byte-address width (upper request address bits dropped)
//   RD_LATENCY  cycles from mem_r_enb to valid mem_r_dat, 0..7
// Optional feature:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses are
//                         rejected with rsp_err; otherwise the address is
//                         aligned down and the access proceeds.
module lsu_mem_master #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY);

  state_t            state;
  logic [2:0]        lat_cnt;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;

  logic [ADDR_W-1:0] w_addr_q;
  logic [31:0]       w_dat_q;
  logic              w_enb_q;
  logic [3:0]        byte_enb_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_enb_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [1:0]        size;
  logic [ADDR_W-1:0] raw_addr;
  logic [ADDR_W-1:0] acc_addr;
  logic              misaligned;
  logic              illegal;
  logic              acc_err;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_be;

  // Address bits above the BRAM window are intentionally discarded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

  // Decode the incoming request: legality, alignment and store lane format.
  // misaligned stays 0 unless the trap feature is built in, in which case
  // the aligned-down address is never used because the request errors out.
  always_comb begin
    size       = bus.req_funct3[1:0];
    raw_addr   = bus.req_addr[ADDR_W-1:0];
    acc_addr   = raw_addr;
    misaligned = 1'b0;
    fmt_wdata  = 32'h0;
    fmt_be     = 4'b0000;

    case (size)
      2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = raw_addr[0];
`endif
        acc_addr[0] = 1'b0;
      end
      2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = |raw_addr[1:0];
`endif
        acc_addr[1:0] = 2'b00;
      end
      default: ;
    endcase

    if (bus.req_we)
      illegal = bus.req_funct3[2] | (size == 2'b11);
    else
      illegal = (size == 2'b11) | (bus.req_funct3 == 3'b110);

    acc_err = illegal | misaligned;

    case (size)
      2'b00: begin
        fmt_wdata = {4{bus.req_wdata[7:0]}};
        fmt_be    = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{bus.req_wdata[15:0]}};
        fmt_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        fmt_wdata = bus.req_wdata;
        fmt_be    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] dat,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = dat[7:0];
      2'b01:   b = dat[15:8];
      2'b10:   b = dat[23:16];
      default: b = dat[31:24];
    endcase
    h = lane[1] ? dat[31:16] : dat[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0, h};
      3'b010:  load_ext = dat;
      default: load_ext = 32'h0;
    endcase
  endfunction

  // Transaction sequencer. Every BRAM and response output is a register
  // loaded on the edge that enters the state it belongs to, so enables line
  // up exactly with their state and drop together on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= 3'd0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      w_addr_q    <= '0;
      w_dat_q     <= 32'h0;
      w_enb_q     <= 1'b0;
      byte_enb_q  <= 4'b0000;
      r_addr_q    <= '0;
      r_enb_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q <= bus.req_funct3;
            lane_q   <= acc_addr[1:0];
            if (acc_err) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_we) begin
              state      <= WRITE;
              w_enb_q    <= 1'b1;
              w_addr_q   <= acc_addr;
              w_dat_q    <= fmt_wdata;
              byte_enb_q <= fmt_be;
            end else begin
              state    <= READ;
              r_enb_q  <= 1'b1;
              r_addr_q <= acc_addr;
              lat_cnt  <= 3'd0;
            end
          end
        end
        WRITE: begin
          w_enb_q     <= 1'b0;
          w_addr_q    <= '0;
          w_dat_q     <= 32'h0;
          byte_enb_q  <= 4'b0000;
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b0;
        end
        READ: begin
          // mem_r_dat is valid in the last read cycle, sampled on its closing edge.
          if (lat_cnt == LAT_LAST) begin
            r_enb_q     <= 1'b0;
            r_addr_q    <= '0;
            lat_cnt     <= 3'd0;
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_ext(bus.mem_r_dat, funct3_q, lane_q);
            rsp_err_q   <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign busy             = (state != IDLE);
  assign bus.mem_w_addr   = w_addr_q;
  assign bus.mem_w_dat    = w_dat_q;
  assign bus.mem_w_enb    = w_enb_q;
  assign bus.mem_byte_enb = byte_enb_q;
  assign bus.mem_r_addr   = r_addr_q;
  assign bus.mem_r_enb    = r_enb_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master
// Directed bench for lsu_mem_master with RD_LATENCY=1 and a byte-enabled
// BRAM model of one-cycle read latency. Expected values are hand-computed.
module tb_lsu_mem_master;

  logic clk;
  logic rst;
  logic busy;

  int n_checks;
  int n_fail;

  int          obs_rsp_at;
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_w_cnt;
  int          obs_r_cnt;
  int          obs_overlap;
  logic [11:0] obs_w_addr;
  logic [31:0] obs_w_dat;
  logic [3:0]  obs_be;
  logic        obs_ready;

  lsu_mem_master_if #(.ADDR_W(12)) bus ();

  lsu_mem_master #(.ADDR_W(12), .RD_LATENCY(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: byte-enabled write, one-cycle registered read, 0 on overlap.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rd_q = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_w_enb) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byte_enb[b]) mem[bus.mem_w_addr[11:2]][8*b +: 8] <= bus.mem_w_dat[8*b +: 8];
    end
    if (bus.mem_r_enb) rd_q <= bus.mem_w_enb ? 32'h0 : mem[bus.mem_r_addr[11:2]];
  end

  assign bus.mem_r_dat = rd_q;

  // Drive one request, then watch cycles T+1.. for memory activity and the
  // response pulse (bounded to 12 cycles; obs_rsp_at stays -1 if none).
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    obs_ready      = bus.req_ready;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    obs_rsp_at  = -1;
    obs_rdata   = 32'hx;
    obs_err     = 1'bx;
    obs_w_cnt   = 0;
    obs_r_cnt   = 0;
    obs_overlap = 0;
    obs_w_addr  = 12'h0;
    obs_w_dat   = 32'h0;
    obs_be      = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.mem_w_enb && bus.mem_r_enb) obs_overlap++;
      if (bus.mem_w_enb) begin
        obs_w_cnt++;
        obs_w_addr = bus.mem_w_addr;
        obs_w_dat  = bus.mem_w_dat;
        obs_be     = bus.mem_byte_enb;
      end
      if (bus.mem_r_enb) obs_r_cnt++;
      if (bus.rsp_valid) begin
        obs_rsp_at = k;
        obs_rdata  = bus.rsp_rdata;
        obs_err    = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.mem_w_enb, bus.mem_r_enb, bus.mem_byte_enb} !== 6'h0) begin n_fail++; $display("[TB] FAIL reset_enables got %b want 0", {bus.mem_w_enb, bus.mem_r_enb, bus.mem_byte_enb}); end
    n_checks++; if ({bus.mem_w_addr, bus.mem_r_addr, bus.mem_w_dat} !== 56'h0) begin n_fail++; $display("[TB] FAIL reset_addr_data got %h want 0", {bus.mem_w_addr, bus.mem_r_addr, bus.mem_w_dat}); end
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin n_fail++; $display("[TB] FAIL reset_rsp got %h want 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}); end
    n_checks++; if ({bus.req_ready, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL reset_ready_busy got %b want 10", {bus.req_ready, busy}); end
    rst = 1'b1;
  endtask

  task automatic test_store_word();
    issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_ready got %b want 1", obs_ready); end
    n_checks++; if (obs_w_cnt !== 1) begin n_fail++; $display("[TB] FAIL sw_wenb_cycles got %0d want 1", obs_w_cnt); end
    n_checks++; if (obs_be !== 4'b1111) begin n_fail++; $display("[TB] FAIL sw_be got %b want 1111", obs_be); end
    n_checks++; if (obs_w_addr !== 12'h010) begin n_fail++; $display("[TB] FAIL sw_waddr got %h want 010", obs_w_addr); end
    n_checks++; if (obs_w_dat !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL sw_wdat got %h want deadbeef", obs_w_dat); end
    n_checks++; if (obs_rsp_at !== 2) begin n_fail++; $display("[TB] FAIL sw_rsp_cycle got %0d want 2", obs_rsp_at); end
    n_checks++; if ({obs_err, obs_r_cnt[3:0]} !== 5'h0) begin n_fail++; $display("[TB] FAIL sw_err_rd got %b/%0d want 0/0", obs_err, obs_r_cnt); end
  endtask

  task automatic test_store_byte_then_load();
    issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
    n_checks++; if (obs_be !== 4'b1000) begin n_fail++; $display("[TB] FAIL sb_be got %b want 1000", obs_be); end
    n_checks++; if (obs_w_dat !== 32'hA5A5_A5A5) begin n_fail++; $display("[TB] FAIL sb_wdat got %h want a5a5a5a5", obs_w_dat); end
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    n_checks++; if (obs_rdata !== 32'hA5AD_BEEF) begin n_fail++; $display("[TB] FAIL lw_rdata got %h want a5adbeef", obs_rdata); end
    n_checks++; if (obs_rsp_at !== 3) begin n_fail++; $display("[TB] FAIL lw_rsp_cycle got %0d want 3", obs_rsp_at); end
    n_checks++; if (obs_r_cnt !== 2) begin n_fail++; $display("[TB] FAIL lw_renb_cycles got %0d want 2", obs_r_cnt); end
    n_checks++; if ({obs_w_cnt[3:0], obs_err} !== 5'h0) begin n_fail++; $display("[TB] FAIL lw_wenb_err got %0d/%b want 0/0", obs_w_cnt, obs_err); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [7];
    logic [31:0] ad  [7];
    logic [31:0] exp [7];
    f3[0] = 3'b000; ad[0] = 32'h12; exp[0] = 32'hFFFF_FFFF;
    f3[1] = 3'b100; ad[1] = 32'h12; exp[1] = 32'h0000_00FF;
    f3[2] = 3'b001; ad[2] = 32'h12; exp[2] = 32'hFFFF_80FF;
    f3[3] = 3'b101; ad[3] = 32'h10; exp[3] = 32'h0000_7F01;
    f3[4] = 3'b000; ad[4] = 32'h13; exp[4] = 32'hFFFF_FF80;
    f3[5] = 3'b100; ad[5] = 32'h11; exp[5] = 32'h0000_007F;
    f3[6] = 3'b001; ad[6] = 32'h10; exp[6] = 32'h0000_7F01;
    issue(1'b1, 3'b010, 32'h0000_0010, 32'h80FF_7F01);
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      n_checks++; if (obs_rdata !== exp[i]) begin n_fail++; $display("[TB] FAIL load_ext[%0d] f3=%b addr=%h got %h want %h", i, f3[i], ad[i], obs_rdata, exp[i]); end
    end
    issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_1234);
    n_checks++; if (obs_be !== 4'b1100) begin n_fail++; $display("[TB] FAIL sh_be got %b want 1100", obs_be); end
    n_checks++; if (obs_w_dat !== 32'h1234_1234) begin n_fail++; $display("[TB] FAIL sh_wdat got %h want 12341234", obs_w_dat); end
  endtask

  task automatic test_misalign();
    issue(1'b0, 3'b010, 32'h0000_0011, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (obs_rsp_at !== 1) begin n_fail++; $display("[TB] FAIL mis_rsp_cycle got %0d want 1", obs_rsp_at); end
    n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_err got %b want 1", obs_err); end
    n_checks++; if (obs_r_cnt !== 0) begin n_fail++; $display("[TB] FAIL mis_renb_cycles got %0d want 0", obs_r_cnt); end
`else
    n_checks++; if (obs_rsp_at !== 3) begin n_fail++; $display("[TB] FAIL mis_rsp_cycle got %0d want 3", obs_rsp_at); end
    n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_err got %b want 0", obs_err); end
    n_checks++; if (obs_rdata !== 32'h80FF_7F01) begin n_fail++; $display("[TB] FAIL mis_rdata got %h want 80ff7f01", obs_rdata); end
`endif
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b011, 32'h0000_0010, 32'h0);
    n_checks++; if (obs_rsp_at !== 1) begin n_fail++; $display("[TB] FAIL ill_ld_rsp_cycle got %0d want 1", obs_rsp_at); end
    n_checks++; if ({obs_err, obs_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("[TB] FAIL ill_ld_err_rdata got %b/%h want 1/0", obs_err, obs_rdata); end
    n_checks++; if (obs_r_cnt + obs_w_cnt !== 0) begin n_fail++; $display("[TB] FAIL ill_ld_mem_enables got %0d want 0", obs_r_cnt + obs_w_cnt); end
    issue(1'b1, 3'b100, 32'h0000_0040, 32'h5555_5555);
    n_checks++; if ({obs_rsp_at[3:0], obs_err} !== {4'd1, 1'b1}) begin n_fail++; $display("[TB] FAIL ill_st_rsp got cycle %0d err %b want 1/1", obs_rsp_at, obs_err); end
    n_checks++; if (obs_w_cnt !== 0) begin n_fail++; $display("[TB] FAIL ill_st_wenb_cycles got %0d want 0", obs_w_cnt); end
  endtask

  task automatic test_back_to_back();
    int overlap;
    int ready_busy;
    int rsp_cnt;
    int ready_cnt;
    logic acc;
    overlap = 0; ready_busy = 0; rsp_cnt = 0; ready_cnt = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'h1122_3344;
    for (int c = 0; c < 28; c++) begin
      if (bus.mem_w_enb && bus.mem_r_enb) overlap++;
      if (busy && bus.req_ready) ready_busy++;
      if (bus.rsp_valid) rsp_cnt++;
      if (bus.req_ready) ready_cnt++;
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.req_we   = ~bus.req_we;
        bus.req_addr = bus.req_we ? 32'h30 : 32'h10;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n_checks++; if (overlap !== 0) begin n_fail++; $display("[TB] FAIL b2b_overlap got %0d want 0", overlap); end
    n_checks++; if (ready_busy !== 0) begin n_fail++; $display("[TB] FAIL b2b_ready_while_busy got %0d want 0", ready_busy); end
    n_checks++; if (rsp_cnt !== 8) begin n_fail++; $display("[TB] FAIL b2b_rsp_count got %0d want 8", rsp_cnt); end
    n_checks++; if (ready_cnt !== 8) begin n_fail++; $display("[TB] FAIL b2b_ready_count got %0d want 8", ready_cnt); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_r_enb !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_renb_before got %b want 1", bus.mem_r_enb); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.mem_r_enb, bus.mem_w_enb, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL rmid_after_reset got %b want 000", {bus.mem_r_enb, bus.mem_w_enb, busy}); end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("[TB] FAIL rmid_rsp_pulses got %0d want 0", pulses); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_store_word();
    test_store_byte_then_load();
    test_load_ext();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
